// File: rtl/inst_queue_param_pkg.sv
// Shared definitions for the instruction queue: default widths, the opcode field
// location, and the load/store opcode classifier.
package inst_queue_param_pkg;

  localparam int INST_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  localparam int OPC_MSB = 6;
  localparam int OPC_LSB = 0;

  localparam logic [6:0] OPCODE_L = 7'b0000011;
  localparam logic [6:0] OPCODE_S = 7'b0100011;

  function automatic logic is_lsb_opcode(input logic [6:0] opc);
    return (opc == OPCODE_L) || (opc == OPCODE_S);
  endfunction

endpackage

// File: rtl/inst_queue_param_iq_storage.sv
// Entry array for the instruction queue: one write port, one asynchronous read port.
// The array holds no reset; validity is tracked entirely by the pointers and count.
module iq_storage
  import inst_queue_param_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = INST_W_DEF + 2 * ADDR_W_DEF + 1
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue_param.sv
// In-order instruction queue between fetch and decode: buffers instruction, PC and
// prediction data, and dispatches the head when the ROB and its target station have room.
module inst_queue_param
  import inst_queue_param_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int INST_W    = INST_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AF_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     rob_full,
  input  logic                     rs_full,
  input  logic                     lsb_full,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INST_W-1:0]        in_inst,
  input  logic [ADDR_W-1:0]        in_pc,
  input  logic                     in_pred_jump,
  input  logic [ADDR_W-1:0]        in_pred_pc,
  output logic                     out_valid,
  output logic [INST_W-1:0]        out_inst,
  output logic [ADDR_W-1:0]        out_pc,
  output logic                     out_pred_jump,
  output logic [ADDR_W-1:0]        out_pred_pc,
  output logic                     out_is_lsb,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = INST_W + 2 * ADDR_W + 1;

  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     cnt;
  logic [EW-1:0]     wdata, rdata;
  logic [INST_W-1:0] head_inst;
  logic [ADDR_W-1:0] head_pc, head_pred_pc;
  logic              head_pred_jump;
  logic              head_is_lsb;
  logic              dispatch, enq, wr_en;

  assign wdata = {in_inst, in_pc, in_pred_jump, in_pred_pc};
  assign {head_inst, head_pc, head_pred_jump, head_pred_pc} = rdata;

  // Class comes from the stored head entry so the decision never lags a cycle.
  assign head_is_lsb = is_lsb_opcode(head_inst[OPC_MSB:OPC_LSB]);
  assign dispatch    = (cnt != '0) && !rob_full && (head_is_lsb ? !lsb_full : !rs_full);
  assign in_ready    = (cnt < CW'(DEPTH)) || dispatch;
  assign enq         = in_valid && in_ready;
  assign wr_en       = !rst && rdy && !flush && enq;

  assign count       = cnt;
  assign almost_full = cnt >= CW'(DEPTH - AF_MARGIN);

  iq_storage #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_storage (
    .clk   (clk),
    .we    (wr_en),
    .waddr (tail),
    .wdata (wdata),
    .raddr (head),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      cnt           <= '0;
      out_valid     <= 1'b0;
      out_is_lsb    <= 1'b0;
      out_inst      <= '0;
      out_pc        <= '0;
      out_pred_jump <= 1'b0;
      out_pred_pc   <= '0;
    end else if (rdy) begin
      if (flush) begin
        head      <= '0;
        tail      <= '0;
        cnt       <= '0;
        out_valid <= 1'b0;
      end else begin
        if (enq) tail <= tail + PW'(1);
        out_valid <= dispatch;
        if (dispatch) begin
          head          <= head + PW'(1);
          out_inst      <= head_inst;
          out_pc        <= head_pc;
          out_pred_jump <= head_pred_jump;
          out_pred_pc   <= head_pred_pc;
          out_is_lsb    <= head_is_lsb;
        end
        case ({enq, dispatch})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

endmodule
